evr_pulse_scheduler: RTL and testbench

// - Sequences a bank of NUM_CH programmable pulse generators from the EVR event stream.
// - Maps each received event code to a channel bitmask through a code-indexed table.
// - Issues one-cycle start strobes to idle, enabled channels and drops triggers aimed at busy channels.
// - Holds double-buffered delay/width/polarity config and commits it only while a channel is idle.
// - Sits between the event decoder / register bus and the pulse generator instances.

---
 rtl/evr_pulse_scheduler.sv | 193 +++++++++++++++++++
 tb/tb_evr_pulse_scheduler.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/evr_pulse_scheduler.sv
// EVR pulse scheduler: event-code map, start strobes and double-buffered channel config.
// Optional per-channel pending trigger is enabled by defining EVR_SCHED_PENDING_EN.
module evr_pulse_scheduler #(
  parameter int NUM_CH = 4,
  parameter int CODE_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [CODE_W-1:0]     event_code,
  input  logic                  event_valid,
  input  logic                  cfg_we,
  input  logic [9:0]            cfg_addr,
  input  logic [31:0]           cfg_wdata,
  output logic [NUM_CH-1:0]     ch_start,
  output logic [32*NUM_CH-1:0]  ch_delay,
  output logic [32*NUM_CH-1:0]  ch_width,
  output logic [NUM_CH-1:0]     ch_polarity,
  output logic [NUM_CH-1:0]     ch_busy,
  output logic [15:0]           drop_count
);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t             state_q [NUM_CH];
  logic [31:0]        busy_cnt [NUM_CH];
  logic [31:0]        sh_delay [NUM_CH];
  logic [31:0]        sh_width [NUM_CH];
  logic [NUM_CH-1:0]  sh_pol;
  logic [NUM_CH-1:0]  enable;

  logic [NUM_CH-1:0]  map_mem [2**CODE_W];

  logic [NUM_CH-1:0]  ch_hit;
  logic [NUM_CH-1:0]  soft_req;
  logic [NUM_CH-1:0]  req_v;
  logic [NUM_CH-1:0]  avail;
  logic [NUM_CH-1:0]  fire;
  logic [NUM_CH-1:0]  drop_vec;
  logic [4:0]         drop_n;
  logic [16:0]        drop_sum;
  logic [15:0]        drop_next;
  logic [32:0]        sum33 [NUM_CH];
  logic [31:0]        load_val [NUM_CH];
  logic               map_we;
  logic               unused_addr;

  assign unused_addr = ^cfg_addr[3:2];
  assign map_we = cfg_we && (cfg_addr[9:8] == 2'b01);

  always_comb begin
    ch_hit   = '0;
    soft_req = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_hit[i] = cfg_we && (cfg_addr[9:8] == 2'b00)
                  && (cfg_addr[7:4] == 4'(i));
      soft_req[i] = ch_hit[i] && (cfg_addr[1:0] == 2'd3)
                    && cfg_wdata[0];
    end
  end

  // Event and soft trigger merge here, so a coincident pair is one request.
  always_comb begin
    req_v = soft_req;
    if (event_valid)
      req_v = req_v | map_mem[event_code];
  end

  always_comb begin
    avail = '0;
    for (int i = 0; i < NUM_CH; i++)
      avail[i] = (state_q[i] == IDLE) && !ch_start[i];
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      sum33[i] = {1'b0, ch_delay[32*i +: 32]}
               + {1'b0, ch_width[32*i +: 32]}
               + 33'd4;
      load_val[i] = sum33[i][32] ? 32'hFFFF_FFFF : sum33[i][31:0];
    end
  end

`ifdef EVR_SCHED_PENDING_EN
  logic [NUM_CH-1:0] pend_q;
  logic [NUM_CH-1:0] pend_d;

  always_comb begin
    fire     = '0;
    drop_vec = '0;
    pend_d   = pend_q;
    for (int i = 0; i < NUM_CH; i++) begin
      fire[i] = (req_v[i] | pend_q[i]) & enable[i] & avail[i];
      drop_vec[i] = req_v[i] & enable[i] & ~avail[i] & pend_q[i];
      if (!enable[i] || fire[i])
        pend_d[i] = 1'b0;
      else if (req_v[i] && !avail[i])
        pend_d[i] = 1'b1;
      if (ch_hit[i] && (cfg_addr[1:0] == 2'd2) && !cfg_wdata[0])
        pend_d[i] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      pend_q <= '0;
    else
      pend_q <= pend_d;
  end
`else
  always_comb begin
    fire     = req_v & enable & avail;
    drop_vec = req_v & enable & ~avail;
  end
`endif

  always_comb begin
    drop_n = '0;
    for (int i = 0; i < NUM_CH; i++)
      drop_n = drop_n + {4'b0, drop_vec[i]};
    drop_sum  = {1'b0, drop_count} + {12'b0, drop_n};
    drop_next = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  always_comb begin
    ch_busy = '0;
    for (int i = 0; i < NUM_CH; i++)
      ch_busy[i] = (state_q[i] == BUSY);
  end

  // Map table is plain RAM: no reset, software fills it before enabling.
  always_ff @(posedge clk) begin
    if (map_we)
      map_mem[cfg_addr[CODE_W-1:0]] <= cfg_wdata[NUM_CH-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ch_start    <= '0;
      ch_delay    <= '0;
      ch_width    <= '0;
      ch_polarity <= '0;
      drop_count  <= '0;
      sh_pol      <= '0;
      enable      <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i]  <= IDLE;
        busy_cnt[i] <= '0;
        sh_delay[i] <= '0;
        sh_width[i] <= '0;
      end
    end else begin
      ch_start   <= fire;
      drop_count <= drop_next;
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_hit[i]) begin
          case (cfg_addr[1:0])
            2'd0: sh_delay[i] <= cfg_wdata;
            2'd1: sh_width[i] <= cfg_wdata;
            2'd2: begin
              enable[i] <= cfg_wdata[0];
              sh_pol[i] <= cfg_wdata[1];
            end
            default: ;
          endcase
        end
        // Commit only when idle and not starting, so a start sees stable config.
        case (state_q[i])
          IDLE: begin
            if (ch_start[i]) begin
              state_q[i]  <= BUSY;
              busy_cnt[i] <= load_val[i];
            end else begin
              ch_delay[32*i +: 32] <= sh_delay[i];
              ch_width[32*i +: 32] <= sh_width[i];
              ch_polarity[i]       <= sh_pol[i];
            end
          end
          BUSY: begin
            if (busy_cnt[i] <= 32'd1)
              state_q[i] <= IDLE;
            else
              busy_cnt[i] <= busy_cnt[i] - 32'd1;
          end
          default: state_q[i] <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_evr_pulse_scheduler.sv
// Directed testbench for evr_pulse_scheduler.
// Default build has NUM_CH=4, CODE_W=8.
module tb_evr_pulse_scheduler;

  logic         clk;
  logic         reset;
  logic [7:0]   event_code;
  logic         event_valid;
  logic         cfg_we;
  logic [9:0]   cfg_addr;
  logic [31:0]  cfg_wdata;
  logic [3:0]   ch_start;
  logic [127:0] ch_delay;
  logic [127:0] ch_width;
  logic [3:0]   ch_polarity;
  logic [3:0]   ch_busy;
  logic [15:0]  drop_count;

  int n_cmp;
  int n_bad;
  int exp_drop;

  evr_pulse_scheduler #(.NUM_CH(4), .CODE_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .event_code  (event_code),
    .event_valid (event_valid),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_wdata   (cfg_wdata),
    .ch_start    (ch_start),
    .ch_delay    (ch_delay),
    .ch_width    (ch_width),
    .ch_polarity (ch_polarity),
    .ch_busy     (ch_busy),
    .drop_count  (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [9:0] a, input logic [31:0] d);
    cfg_we    = 1'b1;
    cfg_addr  = a;
    cfg_wdata = d;
    tick();
    cfg_we    = 1'b0;
  endtask

  task automatic fire_event(input logic [7:0] c);
    event_valid = 1'b1;
    event_code  = c;
    tick();
    event_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (ch_start !== 4'b0 || ch_busy !== 4'b0) begin
      $display("FAIL reset_ctl: start=%b busy=%b expected 0", ch_start, ch_busy);
      n_bad++;
    end
    n_cmp++;
    if (ch_delay !== '0 || ch_width !== '0 || ch_polarity !== 4'b0) begin
      $display("FAIL reset_cfg: delay=%h width=%h pol=%b expected 0",
               ch_delay, ch_width, ch_polarity);
      n_bad++;
    end
    n_cmp++;
    if (drop_count !== 16'h0) begin
      $display("FAIL reset_drop: got %h expected 0", drop_count);
      n_bad++;
    end
    reset = 1'b0;
    tick();
    exp_drop = 0;
  endtask

  task automatic test_basic();
    int n;
    cfg_write(10'h110, 32'h5);
    cfg_write(10'h120, 32'h2);
    cfg_write(10'h130, 32'h1);
    cfg_write(10'h140, 32'h8);
    cfg_write(10'h000, 32'd5);
    cfg_write(10'h001, 32'd3);
    cfg_write(10'h002, 32'h3);
    cfg_write(10'h020, 32'd5);
    cfg_write(10'h021, 32'd3);
    cfg_write(10'h022, 32'h1);
    tick();
    tick();
    fire_event(8'h10);
    n_cmp++;
    if (ch_start !== 4'b0101) begin
      $display("FAIL t1_start: got %b expected 0101", ch_start);
      n_bad++;
    end
    n_cmp++;
    if (ch_delay[31:0] !== 32'd5 || ch_width[95:64] !== 32'd3
        || ch_polarity !== 4'b0001) begin
      $display("FAIL t1_cfg: d0=%0d w2=%0d pol=%b expected 5 3 0001",
               ch_delay[31:0], ch_width[95:64], ch_polarity);
      n_bad++;
    end
    n_cmp++;
    if (ch_busy !== 4'b0000) begin
      $display("FAIL t1_busy_early: got %b expected 0000", ch_busy);
      n_bad++;
    end
    tick();
    n_cmp++;
    if (ch_start !== 4'b0 || ch_busy !== 4'b0101) begin
      $display("FAIL t1_busy_rise: start=%b busy=%b expected 0000 0101",
               ch_start, ch_busy);
      n_bad++;
    end
    n = 0;
    while (ch_busy[0] && n < 50) begin
      n++;
      tick();
    end
    n_cmp++;
    if (n != 12) begin
      $display("FAIL t1_busy_len: got %0d cycles expected 12", n);
      n_bad++;
    end
    n_cmp++;
    if (ch_busy !== 4'b0 || drop_count !== 16'd0) begin
      $display("FAIL t1_end: busy=%b drop=%0d expected 0000 0", ch_busy, drop_count);
      n_bad++;
    end
  endtask

  task automatic test_disabled();
    fire_event(8'h20);
    n_cmp++;
    if (ch_start !== 4'b0) begin
      $display("FAIL t2_start: got %b expected 0000", ch_start);
      n_bad++;
    end
    tick();
    n_cmp++;
    if (ch_busy !== 4'b0 || drop_count !== 16'd0) begin
      $display("FAIL t2_state: busy=%b drop=%0d expected 0000 0", ch_busy, drop_count);
      n_bad++;
    end
  endtask

  task automatic test_drop();
    cfg_write(10'h000, 32'd100);
    tick();
    tick();
    fire_event(8'h30);
    n_cmp++;
    if (ch_start !== 4'b0001) begin
      $display("FAIL t3_start: got %b expected 0001", ch_start);
      n_bad++;
    end
    tick();
    fire_event(8'h30);
`ifdef EVR_SCHED_PENDING_EN
    n_cmp++;
    if (ch_start !== 4'b0 || drop_count !== 16'd0) begin
      $display("FAIL t3_pend: start=%b drop=%0d expected 0000 0", ch_start, drop_count);
      n_bad++;
    end
    fire_event(8'h30);
`endif
    exp_drop = 1;
    n_cmp++;
    if (ch_start !== 4'b0 || drop_count !== 16'd1) begin
      $display("FAIL t3_drop: start=%b drop=%0d expected 0000 1", ch_start, drop_count);
      n_bad++;
    end
  endtask

  task automatic test_commit();
    int n;
    cfg_write(10'h000, 32'd7);
    n_cmp++;
    if (ch_busy[0] !== 1'b1 || ch_delay[31:0] !== 32'd100) begin
      $display("FAIL t4_hold: busy=%b d0=%0d expected 1 100", ch_busy[0], ch_delay[31:0]);
      n_bad++;
    end
    n = 0;
    while (ch_busy[0] && n < 300) begin
      n++;
      tick();
    end
    n_cmp++;
    if (ch_busy[0] !== 1'b0 || ch_delay[31:0] !== 32'd100) begin
      $display("FAIL t4_first_idle: busy=%b d0=%0d expected 0 100",
               ch_busy[0], ch_delay[31:0]);
      n_bad++;
    end
    tick();
    n_cmp++;
    if (ch_delay[31:0] !== 32'd7) begin
      $display("FAIL t4_commit: got %0d expected 7", ch_delay[31:0]);
      n_bad++;
    end
`ifdef EVR_SCHED_PENDING_EN
    n_cmp++;
    if (ch_start[0] !== 1'b1) begin
      $display("FAIL t4_pend_start: got %b expected 1", ch_start[0]);
      n_bad++;
    end
`endif
    n = 0;
    while ((ch_busy[0] || ch_start[0]) && n < 100) begin
      n++;
      tick();
    end
    n_cmp++;
    if (n >= 100) begin
      $display("FAIL t4_timeout: busy=%b expected 0", ch_busy[0]);
      n_bad++;
    end
  endtask

  task automatic test_back_to_back();
    int n;
    cfg_write(10'h032, 32'h1);
    tick();
    tick();
    cfg_we      = 1'b1;
    cfg_addr    = 10'h033;
    cfg_wdata   = 32'h1;
    event_valid = 1'b1;
    event_code  = 8'h40;
    tick();
    cfg_we      = 1'b0;
    event_valid = 1'b0;
    n_cmp++;
    if (ch_start !== 4'b1000 || drop_count !== 16'(exp_drop)) begin
      $display("FAIL t5_merge: start=%b drop=%0d expected 1000 %0d",
               ch_start, drop_count, exp_drop);
      n_bad++;
    end
    tick();
    n = 0;
    while (ch_busy[3] && n < 20) begin
      n++;
      tick();
    end
    n_cmp++;
    if (n != 4) begin
      $display("FAIL t5_min_busy: got %0d cycles expected 4", n);
      n_bad++;
    end
    cfg_write(10'h033, 32'h1);
    n_cmp++;
    if (ch_start !== 4'b1000) begin
      $display("FAIL t5_soft: got %b expected 1000", ch_start);
      n_bad++;
    end
    repeat (6) tick();
  endtask

  task automatic test_reset_mid();
    cfg_write(10'h020, 32'hFFFF_FFFE);
    cfg_write(10'h021, 32'd2);
    tick();
    tick();
    cfg_write(10'h023, 32'h1);
    n_cmp++;
    if (ch_start !== 4'b0100) begin
      $display("FAIL t6_start: got %b expected 0100", ch_start);
      n_bad++;
    end
    repeat (20) tick();
    n_cmp++;
    if (ch_busy[2] !== 1'b1 || ch_delay[95:64] !== 32'hFFFF_FFFE) begin
      $display("FAIL t6_sat_len: busy=%b d2=%h expected 1 fffffffe",
               ch_busy[2], ch_delay[95:64]);
      n_bad++;
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_drop = 0;
    n_cmp++;
    if (ch_busy !== 4'b0 || ch_start !== 4'b0 || drop_count !== 16'd0
        || ch_delay !== '0) begin
      $display("FAIL t6_reset: busy=%b start=%b drop=%0d delay=%h expected 0",
               ch_busy, ch_start, drop_count, ch_delay);
      n_bad++;
    end
  endtask

  task automatic test_drop_saturate();
    cfg_write(10'h150, 32'hF);
    for (int c = 0; c < 4; c++) begin
      cfg_write(10'(c * 16), 32'hFFFF_FFFF);
      cfg_write(10'(c * 16 + 2), 32'h1);
    end
    tick();
    tick();
    event_valid = 1'b1;
    event_code  = 8'h50;
    tick();
    n_cmp++;
    if (ch_start !== 4'b1111) begin
      $display("FAIL sat_start: got %b expected 1111", ch_start);
      n_bad++;
    end
`ifdef EVR_SCHED_PENDING_EN
    tick();
`endif
    repeat (16383) tick();
    n_cmp++;
    if (drop_count !== 16'hFFFC) begin
      $display("FAIL sat_pre: got %h expected fffc", drop_count);
      n_bad++;
    end
    tick();
    n_cmp++;
    if (drop_count !== 16'hFFFF) begin
      $display("FAIL sat_multi: got %h expected ffff", drop_count);
      n_bad++;
    end
    event_code = 8'h30;
    tick();
    event_valid = 1'b0;
    n_cmp++;
    if (drop_count !== 16'hFFFF) begin
      $display("FAIL sat_single: got %h expected ffff", drop_count);
      n_bad++;
    end
    cfg_write(10'h002, 32'h0);
    tick();
    n_cmp++;
    if (ch_busy !== 4'b1111) begin
      $display("FAIL disable_busy: got %b expected 1111", ch_busy);
      n_bad++;
    end
  endtask

  initial begin
    n_cmp       = 0;
    n_bad       = 0;
    exp_drop    = 0;
    reset       = 1'b1;
    event_code  = '0;
    event_valid = 1'b0;
    cfg_we      = 1'b0;
    cfg_addr    = '0;
    cfg_wdata   = '0;
    test_reset();
    test_basic();
    test_disabled();
    test_drop();
    test_commit();
    test_back_to_back();
    test_reset_mid();
    test_drop_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
